// File: rtl/vga_pkg.sv
// Shared VGA raster constants: coordinate width, default 640x480@60 timing and a range helper.
// Purely declarative; no logic or state.
package vga_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1 << COORD_W;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    function automatic logic in_range(input logic [COORD_W-1:0] val,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (32'(val) >= lo) && (32'(val) <= hi);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: registered one-cycle ce every DIV clocks, first ce DIV clocks after reset.
// No backpressure; DIV=1 holds ce high after the first clock out of reset.
module clk_en_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic ce
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          ce_q;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ce_q  <= (div_q == DIV_LAST);
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, h/v counters and sync/blank/frame_start, all registered together.
// Counts advance on the clock edge that ends a pix_ce cycle; no backpressure, free running.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_ce,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic               tick;
    logic [COORD_W-1:0] hcount_q, hcount_d;
    logic [COORD_W-1:0] vcount_q, vcount_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               blank_q, blank_d;
    logic               frame_start_q;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_pix_div (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (tick)
    );

    // Decode from the next counts so sync/blank land on the same edge as the counters.
    always_comb begin
        hcount_d = hcount_q + COORD_W'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + COORD_W'(1);
        end
        hsync_d = in_range(hcount_d, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d = in_range(vcount_d, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        blank_d = (32'(hcount_d) >= H_ACTIVE) || (32'(vcount_d) >= V_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (tick) begin
                hcount_q      <= hcount_d;
                vcount_q      <= vcount_d;
                hsync_q       <= hsync_d;
                vsync_q       <= vsync_d;
                blank_q       <= blank_d;
                frame_start_q <= (hcount_d == '0) && (vcount_d == '0);
            end
        end
    end

    assign pix_ce      = tick;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Four configurations run side by side against an arithmetic raster model indexed by clocks since reset.
// Small-timing instances make frame-level behaviour reachable in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    longint k = 0;

    logic       a_ce, a_hs, a_vs, a_bl, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_ce, b_hs, b_vs, b_bl, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_ce, c_hs, c_vs, c_bl, c_fs;
    logic [9:0] c_h, c_v;
    logic       d_ce, d_hs, d_vs, d_bl, d_fs;
    logic [9:0] d_h, d_v;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_ce(a_ce), .hcount(a_h), .vcount(a_v),
        .hsync(a_hs), .vsync(a_vs), .blank(a_bl), .frame_start(a_fs));

    vga_timing_gen #(.CLK_DIV(2), .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_ce(b_ce), .hcount(b_h), .vcount(b_v),
        .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .frame_start(b_fs));

    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_ce(c_ce), .hcount(c_h), .vcount(c_v),
        .hsync(c_hs), .vsync(c_vs), .blank(c_bl), .frame_start(c_fs));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .pix_ce(d_ce), .hcount(d_h), .vcount(d_v),
        .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .frame_start(d_fs));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", tag, $time, k, got, exp);
        end
    endtask

    // Clocks since reset release -> pixel index -> raster position; sync/blank from the range rules.
    task automatic check_dut(input string nm, input int div,
                             input int ha, input int hfp, input int hsw, input int hbp,
                             input int va, input int vfp, input int vsw, input int vbp,
                             input bit pol, input logic ce, input logic [9:0] h, input logic [9:0] v,
                             input logic hs, input logic vs, input logic bl, input logic fs);
        longint ht, vt, n, p;
        longint eh, ev;
        bit e_ce, e_hs, e_vs, e_bl, e_fs;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        e_ce = (k >= div) && (k % div == 0);
        n    = (k >= 1) ? (k - 1) / div : 0;
        p    = n % (ht * vt);
        eh   = p % ht;
        ev   = p / ht;
        e_hs = (eh >= ha + hfp && eh < ha + hfp + hsw) ? pol : !pol;
        e_vs = (ev >= va + vfp && ev < va + vfp + vsw) ? pol : !pol;
        e_bl = (eh >= ha) || (ev >= va);
        e_fs = (k >= div + 1) && ((k - 1) % div == 0) && (p == 0);
        chk({nm, ".pix_ce"},      32'(ce), 32'(e_ce));
        chk({nm, ".hcount"},      32'(h),  32'(eh));
        chk({nm, ".vcount"},      32'(v),  32'(ev));
        chk({nm, ".hsync"},       32'(hs), 32'(e_hs));
        chk({nm, ".vsync"},       32'(vs), 32'(e_vs));
        chk({nm, ".blank"},       32'(bl), 32'(e_bl));
        chk({nm, ".frame_start"}, 32'(fs), 32'(e_fs));
    endtask

    always @(posedge clk) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    always @(negedge clk) begin
        if (checking) begin
            check_dut("a", 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, a_ce, a_h, a_v, a_hs, a_vs, a_bl, a_fs);
            check_dut("b", 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, b_ce, b_h, b_v, b_hs, b_vs, b_bl, b_fs);
            check_dut("c", 3, 8, 2, 3, 2, 6, 1, 2, 2, 1'b0, c_ce, c_h, c_v, c_hs, c_vs, c_bl, c_fs);
            check_dut("d", 1, 8, 2, 3, 2, 6, 1, 2, 2, 1'b1, d_ce, d_h, d_v, d_hs, d_vs, d_bl, d_fs);
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int  guard;
        bit  found;
        rst_n = 1'b0;
        @(posedge clk);
        #1 checking = 1'b1;
        run(2);
        rst_n = 1'b1;

        // Two full default lines plus many small frames.
        run(7000);

        // Mid-line reset on the default instance while hsync is active.
        found = 1'b0;
        for (guard = 0; guard < 4000 && !found; guard++) begin
            @(negedge clk);
            if (a_h == 10'd700) found = 1'b1;
        end
        chk("wait_a_h700", 32'(found), 32'd1);
        pulse_reset(1);
        run(4000);

        // Reset the small instance while both syncs are asserted.
        found = 1'b0;
        for (guard = 0; guard < 2000 && !found; guard++) begin
            @(negedge clk);
            if (c_h == 10'd12 && c_v == 10'd8) found = 1'b1;
        end
        chk("wait_c_h12v8", 32'(found), 32'd1);
        pulse_reset(1);
        run(1200);

        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(50, 2500)));
            pulse_reset(int'($urandom_range(1, 3)));
        end
        run(700);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
